muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the EX-stage multiply/divide resource of the MIPS pipeline.

---
 rtl/alu_defs.sv | 22 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_sequencer.sv | 120 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// ALU control codes shared by the EX-stage ALU decoder and the multiply/divide sequencer.
package alu_defs;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiply or restoring divide.
// hi = partial product high / partial remainder, lo = multiplier bits / partial quotient.
module muldiv_step
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  step_mode_t         mode,
  output logic [WIDTH-1:0]   hi_next,
  output logic [WIDTH-1:0]   lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, operand};
    if (mode == STEP_MUL) begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], acc[WIDTH-1:1]};
    end else begin
      // A borrow out of the trial subtraction means the divisor did not fit: restore.
      hi_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_next = {acc[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multi-cycle MULT/DIV sequencer: iterates on operand magnitudes one bit per
// cycle, stalls the pipeline meanwhile, then sign-fixes and commits HI/LO.
module muldiv_sequencer
  import alu_defs::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALU_Control,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     operand;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     step_hi, step_lo;
  logic [WIDTH-1:0]     res_hi, res_lo;
  logic                 a_neg, b_neg, div_op, dz;
  logic                 is_mult, is_div, accept, b_zero;

  assign is_mult = (state == IDLE) && Start && !Flush && (ALU_Control == ALU_MULT);
  assign is_div  = (state == IDLE) && Start && !Flush && (ALU_Control == ALU_DIV);
  assign accept  = is_mult || is_div;
  assign b_zero  = (SrcB == '0);
  assign a_mag   = SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign b_mag   = SrcB[WIDTH-1] ? -SrcB : SrcB;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .operand (operand),
    .mode    (div_op ? STEP_DIV : STEP_MUL),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      operand   <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      div_op    <= 1'b0;
      dz        <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      state <= state_next;
      Busy  <= (state_next == MUL) || (state_next == DIV);
      Done  <= (state_next == DONE);
      if (accept) begin
        a_neg     <= SrcA[WIDTH-1];
        b_neg     <= SrcB[WIDTH-1];
        div_op    <= is_div;
        dz        <= is_div && b_zero;
        DivByZero <= is_div && b_zero;
        cnt       <= CNT_W'(WIDTH);
        // Divide-by-zero parks |SrcA| in the remainder half so the sign fix returns SrcA.
        acc       <= (is_div && b_zero) ? {a_mag, {WIDTH{1'b0}}}
                                        : {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        operand   <= is_div ? b_mag : a_mag;
      end else if (state == MUL || state == DIV) begin
        acc <= {step_hi, step_lo};
        cnt <= cnt - 1'b1;
      end
      if (state == DONE && !Flush) begin
        Hi <= res_hi;
        Lo <= res_lo;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (is_mult)     state_next = MUL;
        else if (is_div) state_next = b_zero ? DONE : DIV;
      end
      MUL, DIV: begin
        if (Flush)                     state_next = IDLE;
        else if (cnt == CNT_W'(1))     state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Stall  = accept || (((state == MUL) || (state == DIV)) && !Flush);
    prod   = (a_neg ^ b_neg) ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_op) begin
      res_hi = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = dz ? '1 : ((a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed MULT/DIV results, stall length,
// divide-by-zero, overflow case, flush abort and mid-operation reset.
module tb_muldiv_sequencer;
  import alu_defs::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [3:0]   ALU_Control = '0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Stall, Busy, Done, DivByZero;
  logic [W-1:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  int stalls;
  logic done_flag;
  logic done_seen;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ALU_Control (ALU_Control),
    .Start       (Start),
    .Flush       (Flush),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .Stall       (Stall),
    .Busy        (Busy),
    .Done        (Done),
    .DivByZero   (DivByZero),
    .Hi          (Hi),
    .Lo          (Lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one op, counts Stall cycles (bounded), reports Done in the first unstalled
  // cycle, then steps past the commit edge.
  task automatic do_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int n_stall, output logic done_at_end);
    ALU_Control = code;
    SrcA        = a;
    SrcB        = b;
    Start       = 1'b1;
    n_stall     = 0;
    #1;
    while (Stall === 1'b1 && n_stall < 100) begin
      n_stall++;
      tick();
      Start       = 1'b0;
      ALU_Control = '0;
      #1;
    end
    if (n_stall >= 100) begin
      errors++;
      $error("FAIL wait_expired: Stall still high after %0d cycles", n_stall);
    end
    done_at_end = Done;
    tick();
  endtask

  initial begin
    #2;
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_dz", DivByZero, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Non-MULT/DIV code must be ignored
    ALU_Control = ALU_ADD;
    Start = 1'b1;
    #1;
    chk("ign_stall", Stall, 1'b0);
    tick();
    Start = 1'b0;
    ALU_Control = '0;
    #1;
    chk("ign_busy", Busy, 1'b0);

    // 1: 7 * -3 = -21
    do_op(ALU_MULT, 32'd7, 32'hFFFF_FFFD, stalls, done_flag);
    chk("mul_stalls", stalls, 33);
    chk("mul_done", done_flag, 1'b1);
    chk("mul_hi", Hi, 32'hFFFF_FFFF);
    chk("mul_lo", Lo, 32'hFFFF_FFEB);
    chk("mul_done_clr", Done, 1'b0);

    // 2: -7 / 2 -> q=-3, r=-1
    do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, stalls, done_flag);
    chk("div_stalls", stalls, 33);
    chk("div_done", done_flag, 1'b1);
    chk("div_lo", Lo, 32'hFFFF_FFFD);
    chk("div_hi", Hi, 32'hFFFF_FFFF);
    chk("div_dz", DivByZero, 1'b0);

    // 3: divide by zero
    do_op(ALU_DIV, 32'h1234_5678, 32'h0, stalls, done_flag);
    chk("dz_stalls", stalls, 1);
    chk("dz_done", done_flag, 1'b1);
    chk("dz_hi", Hi, 32'h1234_5678);
    chk("dz_lo", Lo, 32'hFFFF_FFFF);
    chk("dz_flag", DivByZero, 1'b1);

    // 4: most-negative / -1
    do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stalls, done_flag);
    chk("ovf_lo", Lo, 32'h8000_0000);
    chk("ovf_hi", Hi, 32'h0);
    chk("ovf_dz_clr", DivByZero, 1'b0);

    // 5: preload Hi/Lo = 1/2 via 5/2, then flush a MULT at iteration 10
    do_op(ALU_DIV, 32'd5, 32'd2, stalls, done_flag);
    chk("pre_hi", Hi, 32'h1);
    chk("pre_lo", Lo, 32'h2);
    ALU_Control = ALU_MULT;
    SrcA = 32'd1000;
    SrcB = 32'd1000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ALU_Control = '0;
    repeat (9) tick();
    chk("fl_busy", Busy, 1'b1);
    Flush = 1'b1;
    #1;
    chk("fl_stall", Stall, 1'b0);
    tick();
    Flush = 1'b0;
    #1;
    chk("fl_busy_clr", Busy, 1'b0);
    chk("fl_stall_idle", Stall, 1'b0);
    done_seen = 1'b0;
    repeat (40) begin
      if (Done === 1'b1) done_seen = 1'b1;
      tick();
    end
    chk("fl_no_done", done_seen, 1'b0);
    chk("fl_hi", Hi, 32'h1);
    chk("fl_lo", Lo, 32'h2);

    // 6: async reset in the middle of a DIV
    ALU_Control = ALU_DIV;
    SrcA = 32'd100;
    SrcB = 32'd7;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ALU_Control = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("ar_hi", Hi, 32'h0);
    chk("ar_lo", Lo, 32'h0);
    chk("ar_busy", Busy, 1'b0);
    chk("ar_done", Done, 1'b0);
    chk("ar_dz", DivByZero, 1'b0);
    chk("ar_stall", Stall, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(ALU_MULT, 32'd3, 32'd4, stalls, done_flag);
    chk("ar_mul_stalls", stalls, 33);
    chk("ar_mul_lo", Lo, 32'd12);
    chk("ar_mul_hi", Hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
